// File: rtl/hazard_scoreboard_pkg.sv
// Shared definitions for the hazard scoreboard: stage numbering, tracked-entry
// record and forwarding-select encoding.
package hazard_scoreboard_pkg;

    // Stage numbers double as the fwd_sel encoding: 0 reads the register file,
    // k forwards from post-decode stage k.
    localparam int STG_RF  = 0;
    localparam int STG_EX  = 1;
    localparam int STG_MEM = 2;
    localparam int STG_WB  = 3;

    localparam int FWD_RF  = STG_RF;

    // Register field is sized for up to 256 architectural registers; narrower
    // indices are zero-extended into it.
    localparam int RD_W = 8;

    typedef struct packed {
        logic            vld;
        logic [RD_W-1:0] rd;
        logic            ld;
    } entry_t;

endpackage

// File: rtl/hazard_scoreboard_match.sv
// Per-operand RAW resolver: finds the youngest tracked write to a source
// register and reports whether its data can be forwarded yet.
module hazard_match
    import hazard_scoreboard_pkg::*;
#(
    parameter int DEPTH      = 3,
    parameter int LOAD_READY = 2,
    parameter int ZERO_REG   = 1,
    parameter int SW         = 2
) (
    input  logic [RD_W-1:0]      src,
    input  logic                 used,
    input  entry_t [DEPTH:1]     ents,
    output logic                 hit,
    output logic [SW-1:0]        sel,
    output logic                 not_ready
);

    logic enable_s;
    logic match_s;

    // Scan oldest to youngest so the youngest match overwrites older ones.
    always_comb begin
        hit       = 1'b0;
        sel       = SW'(FWD_RF);
        not_ready = 1'b0;
        match_s   = 1'b0;
        enable_s  = used && !((ZERO_REG != 0) && (src == {RD_W{1'b0}}));
        for (int k = DEPTH; k >= 1; k--) begin
            match_s   = enable_s && ents[k].vld && (ents[k].rd == src);
            hit       = match_s ? 1'b1 : hit;
            sel       = match_s ? SW'(k) : sel;
            not_ready = match_s ? (ents[k].ld && (k < LOAD_READY)) : not_ready;
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-stage hazard/forwarding controller: tracks in-flight writes through a
// DEPTH-deep shift register, resolves load-use stalls and forwarding selects.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int NREG       = 16,
    parameter int DEPTH      = 3,
    parameter int LOAD_READY = 2,
    parameter int ZERO_REG   = 1,
    parameter int CNT_W      = 16,
    localparam int RW        = $clog2(NREG),
    localparam int SW        = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [RW-1:0]    id_rs1,
    input  logic             id_rs1_used,
    input  logic [RW-1:0]    id_rs2,
    input  logic             id_rs2_used,
    input  logic [RW-1:0]    id_rd,
    input  logic             id_wr,
    input  logic             id_is_load,
    input  logic             flush,
    output logic             stall,
    output logic [SW-1:0]    fwd_sel1,
    output logic [SW-1:0]    fwd_sel2,
    output logic [SW-1:0]    inflight,
    output logic [CNT_W-1:0] stall_cnt
);

    entry_t [DEPTH:1] ents_r;
    entry_t           new_s;
    logic [SW-1:0]    inflight_r;
    logic [SW-1:0]    inflight_nxt_s;
    logic [CNT_W-1:0] stall_cnt_r;

    logic             hit1_s, hit2_s, nr1_s, nr2_s, stall_s;
    logic [SW-1:0]    sel1_s, sel2_s;

    hazard_match #(
        .DEPTH(DEPTH), .LOAD_READY(LOAD_READY), .ZERO_REG(ZERO_REG), .SW(SW)
    ) u_match1 (
        .src       (RD_W'(id_rs1)),
        .used      (id_valid && id_rs1_used),
        .ents      (ents_r),
        .hit       (hit1_s),
        .sel       (sel1_s),
        .not_ready (nr1_s)
    );

    hazard_match #(
        .DEPTH(DEPTH), .LOAD_READY(LOAD_READY), .ZERO_REG(ZERO_REG), .SW(SW)
    ) u_match2 (
        .src       (RD_W'(id_rs2)),
        .used      (id_valid && id_rs2_used),
        .ents      (ents_r),
        .hit       (hit2_s),
        .sel       (sel2_s),
        .not_ready (nr2_s)
    );

    // Stall/forward resolution; a flush suppresses the stall outright.
    always_comb begin
        stall_s  = !flush && ((hit1_s && nr1_s) || (hit2_s && nr2_s));
        fwd_sel1 = (stall_s || !hit1_s || nr1_s) ? SW'(FWD_RF) : sel1_s;
        fwd_sel2 = (stall_s || !hit2_s || nr2_s) ? SW'(FWD_RF) : sel2_s;
    end

    // Entry entering EX: a bubble unless a real writing instruction proceeds.
    always_comb begin
        new_s.vld = (flush || stall_s || !id_valid) ? 1'b0 : id_wr;
        new_s.rd  = RD_W'(id_rd);
        new_s.ld  = id_is_load;
    end

    // Occupancy after the coming shift, so the registered count tracks the entries.
    always_comb begin
        inflight_nxt_s = SW'(new_s.vld);
        for (int k = 1; k < DEPTH; k++) begin
            inflight_nxt_s = inflight_nxt_s + SW'(ents_r[k].vld);
        end
    end

    // Pipeline shift register, occupancy and saturating stall counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ents_r      <= '0;
            inflight_r  <= '0;
            stall_cnt_r <= '0;
        end else begin
            ents_r[1] <= new_s;
            for (int k = 2; k <= DEPTH; k++) begin
                ents_r[k] <= ents_r[k-1];
            end
            inflight_r <= inflight_nxt_s;
            if (stall_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
                stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
        end
    end

    assign stall     = stall_s;
    assign inflight  = inflight_r;
    assign stall_cnt = stall_cnt_r;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed scoreboard bench: the driver queues hand-computed expectations, a
// monitor compares them against the DUT once per cycle.
module tb_hazard_scoreboard;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        id_valid = 1'b0, id_rs1_used = 1'b0, id_rs2_used = 1'b0;
    logic        id_wr = 1'b0, id_is_load = 1'b0, flush = 1'b0;
    logic [3:0]  id_rs1 = 4'd0, id_rs2 = 4'd0, id_rd = 4'd0;
    logic        stall, stall_z;
    logic [1:0]  fwd_sel1, fwd_sel2, inflight;
    logic [1:0]  fwd_sel1_z, fwd_sel2_z, inflight_z;
    logic [15:0] stall_cnt;
    logic [2:0]  stall_cnt_z;

    typedef struct {
        string       name;
        logic        stall;
        logic [1:0]  f1, f2, inf;
        logic [15:0] cnt;
        logic        chkz;
        logic [1:0]  f1z;
        logic [2:0]  cntz;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    hazard_scoreboard dut (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs1_used(id_rs1_used),
        .id_rs2(id_rs2), .id_rs2_used(id_rs2_used),
        .id_rd(id_rd), .id_wr(id_wr), .id_is_load(id_is_load), .flush(flush),
        .stall(stall), .fwd_sel1(fwd_sel1), .fwd_sel2(fwd_sel2),
        .inflight(inflight), .stall_cnt(stall_cnt)
    );

    hazard_scoreboard #(.ZERO_REG(0), .CNT_W(3)) dut_z (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs1_used(id_rs1_used),
        .id_rs2(id_rs2), .id_rs2_used(id_rs2_used),
        .id_rd(id_rd), .id_wr(id_wr), .id_is_load(id_is_load), .flush(flush),
        .stall(stall_z), .fwd_sel1(fwd_sel1_z), .fwd_sel2(fwd_sel2_z),
        .inflight(inflight_z), .stall_cnt(stall_cnt_z)
    );

    task automatic vec(input string nm, input logic r, input logic v,
                       input logic [3:0] s1, input logic u1,
                       input logic [3:0] s2, input logic u2,
                       input logic [3:0] d, input logic w, input logic ld,
                       input logic fl, input logic es,
                       input logic [1:0] e1, input logic [1:0] e2,
                       input logic [1:0] ei, input logic [15:0] ec,
                       input logic cz, input logic [1:0] ez1,
                       input logic [2:0] ezc);
        exp_t e;
        @(negedge clk);
        rst = r; id_valid = v;
        id_rs1 = s1; id_rs1_used = u1; id_rs2 = s2; id_rs2_used = u2;
        id_rd = d; id_wr = w; id_is_load = ld; flush = fl;
        e.name = nm; e.stall = es; e.f1 = e1; e.f2 = e2; e.inf = ei; e.cnt = ec;
        e.chkz = cz; e.f1z = ez1; e.cntz = ezc;
        q.push_back(e);
    endtask

    // Monitor: outputs settle shortly after the driver's negedge update.
    initial begin
        exp_t e;
        logic ok;
        forever begin
            @(negedge clk);
            #2;
            if (q.size() > 0) begin
                e = q.pop_front();
                ok = (stall === e.stall) && (fwd_sel1 === e.f1) && (fwd_sel2 === e.f2) &&
                     (inflight === e.inf) && (stall_cnt === e.cnt);
                if (e.chkz)
                    ok = ok && (fwd_sel1_z === e.f1z) && (stall_cnt_z === e.cntz);
                n_vec++;
                if (!ok) begin
                    n_bad++;
                    $display("FAIL %s: got stall=%b f1=%0d f2=%0d inf=%0d cnt=%0d z_f1=%0d z_cnt=%0d; want stall=%b f1=%0d f2=%0d inf=%0d cnt=%0d z_f1=%0d z_cnt=%0d (z checked=%b)",
                             e.name, stall, fwd_sel1, fwd_sel2, inflight, stall_cnt, fwd_sel1_z, stall_cnt_z,
                             e.stall, e.f1, e.f2, e.inf, e.cnt, e.f1z, e.cntz, e.chkz);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout, want finish");
        $fatal(1);
    end

    initial begin
        //       name           rst v  rs1  u rs2  u rd   w ld fl  st f1 f2 inf cnt      cz z1 zc
        vec("reset",        1, 0, 4'd0,0,4'd0,0,4'd0,0,0,0, 0,2'd0,2'd0,2'd0,16'd0, 1,2'd0,3'd0);
        vec("add_r3",       0, 1, 4'd0,0,4'd0,0,4'd3,1,0,0, 0,2'd0,2'd0,2'd0,16'd0, 0,2'd0,3'd0);
        vec("fwd_ex",       0, 1, 4'd3,1,4'd0,0,4'd0,0,0,0, 0,2'd1,2'd0,2'd1,16'd0, 0,2'd0,3'd0);
        vec("fwd_mem",      0, 1, 4'd0,0,4'd3,1,4'd0,0,0,0, 0,2'd0,2'd2,2'd1,16'd0, 0,2'd0,3'd0);
        vec("fwd_wb",       0, 1, 4'd3,1,4'd0,0,4'd4,1,0,0, 0,2'd3,2'd0,2'd1,16'd0, 0,2'd0,3'd0);
        vec("sub_r4",       0, 1, 4'd4,1,4'd0,0,4'd4,1,0,0, 0,2'd1,2'd0,2'd1,16'd0, 0,2'd0,3'd0);
        vec("youngest",     0, 1, 4'd4,1,4'd4,1,4'd0,0,0,0, 0,2'd1,2'd1,2'd2,16'd0, 0,2'd0,3'd0);
        vec("add_r0",       0, 1, 4'd0,0,4'd0,0,4'd0,1,0,0, 0,2'd0,2'd0,2'd2,16'd0, 0,2'd0,3'd0);
        vec("zero_reg",     0, 1, 4'd0,1,4'd0,0,4'd0,0,0,0, 0,2'd0,2'd0,2'd2,16'd0, 1,2'd1,3'd0);
        vec("lw_r5",        0, 1, 4'd0,0,4'd0,0,4'd5,1,1,0, 0,2'd0,2'd0,2'd1,16'd0, 0,2'd0,3'd0);
        vec("load_use",     0, 1, 4'd5,1,4'd0,0,4'd6,1,0,0, 1,2'd0,2'd0,2'd2,16'd0, 0,2'd0,3'd0);
        vec("after_stall",  0, 1, 4'd5,1,4'd0,0,4'd6,1,0,0, 0,2'd2,2'd0,2'd1,16'd1, 0,2'd0,3'd0);
        vec("lw_r2",        0, 1, 4'd0,0,4'd0,0,4'd2,1,1,0, 0,2'd0,2'd0,2'd2,16'd1, 0,2'd0,3'd0);
        vec("flush_stall",  0, 1, 4'd2,1,4'd0,0,4'd7,1,0,1, 0,2'd0,2'd0,2'd2,16'd1, 0,2'd0,3'd0);
        vec("flush_bubble", 0, 0, 4'd0,0,4'd0,0,4'd0,0,0,0, 0,2'd0,2'd0,2'd2,16'd1, 0,2'd0,3'd0);
        vec("lw_r8",        0, 1, 4'd0,0,4'd0,0,4'd8,1,1,0, 0,2'd0,2'd0,2'd1,16'd1, 0,2'd0,3'd0);
        vec("load_use_rs2", 0, 1, 4'd0,0,4'd8,1,4'd9,1,0,0, 1,2'd0,2'd0,2'd1,16'd1, 0,2'd0,3'd0);
        vec("rs2_release",  0, 1, 4'd0,0,4'd8,1,4'd9,1,0,0, 0,2'd0,2'd2,2'd1,16'd2, 0,2'd0,3'd0);
        vec("add_r10",      0, 1, 4'd0,0,4'd0,0,4'd10,1,0,0,0,2'd0,2'd0,2'd2,16'd2, 0,2'd0,3'd0);
        vec("add_r11",      0, 1, 4'd10,1,4'd0,0,4'd11,1,0,0,0,2'd1,2'd0,2'd2,16'd2, 0,2'd0,3'd0);
        vec("three_inflt",  0, 1, 4'd10,1,4'd9,1,4'd0,0,0,0, 0,2'd2,2'd3,2'd3,16'd2, 0,2'd0,3'd0);
        vec("reset_mid",    1, 1, 4'd10,1,4'd9,1,4'd0,0,0,0, 0,2'd0,2'd0,2'd0,16'd0, 1,2'd0,3'd0);
        vec("post_reset",   0, 1, 4'd10,1,4'd9,1,4'd0,0,0,0, 0,2'd0,2'd0,2'd0,16'd0, 1,2'd0,3'd0);
        // Repeated load-use pairs drive the narrow counter into saturation.
        for (int i = 0; i < 9; i++) begin
            vec("sat_lw",   0, 1, 4'd0,0,4'd0,0,4'd5,1,1,0, 0,2'd0,2'd0,(i == 0) ? 2'd0 : 2'd1,
                16'(i), 1, 2'd0, (i > 7) ? 3'd7 : 3'(i));
            vec("sat_stall",0, 1, 4'd5,1,4'd0,0,4'd0,0,0,0, 1,2'd0,2'd0,2'd1,
                16'(i), 1, 2'd0, (i > 7) ? 3'd7 : 3'(i));
            vec("sat_fwd",  0, 1, 4'd5,1,4'd0,0,4'd0,0,0,0, 0,2'd2,2'd0,2'd1,
                16'(i + 1), 1, 2'd2, (i + 1 > 7) ? 3'd7 : 3'(i + 1));
        end
        vec("sat_final",    0, 0, 4'd0,0,4'd0,0,4'd0,0,0,0, 0,2'd0,2'd0,2'd1,16'd9, 1,2'd0,3'd7);
        @(negedge clk);
        @(negedge clk);
        #5;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending expectations, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
